// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
//
// Produces one quotient bit per cycle from the magnitudes of the operands.
// Signs are fixed up on the way out. Divide-by-zero and signed overflow
// resolve to the RISC-V defined results. With EARLY_OUT=1 they finish in one
// cycle; otherwise they run the full XLEN iterations and still return the
// defined results.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_i     synchronous active-high reset
//   start_i   request, accepted only while busy_o==0
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled on accept)
//   a_i       dividend (sampled on accept)
//   b_i       divisor (sampled on accept)
//   kill_i    abort the in-flight operation
//   busy_o    high in CALC and DONE
//   done_o    one-cycle pulse, result_o valid in that cycle
//   result_o  quotient or remainder, held until the next done_o

module div_unit #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] b_abs_q, b_abs_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    // Request decode (valid only in the accept cycle)
    logic            in_signed;
    logic            in_a_neg, in_b_neg;
    logic [XLEN-1:0] in_a_abs, in_b_abs;
    logic            in_div0, in_ovf;

    assign in_signed = ~op_i[0];
    assign in_a_neg  = in_signed & a_i[XLEN-1];
    assign in_b_neg  = in_signed & b_i[XLEN-1];
    assign in_a_abs  = in_a_neg ? (~a_i + 1'b1) : a_i;
    assign in_b_abs  = in_b_neg ? (~b_i + 1'b1) : b_i;
    assign in_div0   = (b_i == '0);
    assign in_ovf    = in_signed & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);

    // One restoring step. The partial remainder stays below |b|, so the
    // shifted value needs one extra bit. The top bit of the difference is
    // the borrow.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] rem_trial;
    logic          trial_ok;

    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign rem_trial = rem_sh - {1'b0, b_abs_q};
    assign trial_ok  = ~rem_trial[XLEN];

    // Final value with special cases and sign fix-up
    logic [XLEN-1:0] res_final;

    always_comb begin
        res_final = '0;
        if (div0_q) begin
            res_final = is_rem_q ? a_q : '1;
        end else if (ovf_q) begin
            res_final = is_rem_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else if (is_rem_q) begin
            res_final = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            res_final = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        b_abs_d   = b_abs_q;
        a_d       = a_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            StIdle: begin
                // A kill in the same cycle drops the request.
                if (start_i && !kill_i) begin
                    a_d       = a_i;
                    b_abs_d   = in_b_abs;
                    quo_d     = in_a_abs;
                    rem_d     = '0;
                    cnt_d     = CntW'(XLEN - 1);
                    is_rem_d  = op_i[1];
                    div0_d    = in_div0;
                    ovf_d     = in_ovf;
                    neg_quo_d = in_a_neg ^ in_b_neg;
                    neg_rem_d = in_a_neg;
                    state_d   = (EARLY_OUT && (in_div0 || in_ovf)) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else begin
                    quo_d = {quo_q[XLEN-2:0], trial_ok};
                    rem_d = trial_ok ? rem_trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDone: begin
                // A killed op still shows done_o this cycle but leaves the
                // held result untouched.
                if (!kill_i) begin
                    result_d = res_final;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            quo_q     <= '0;
            b_abs_q   <= '0;
            a_q       <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            b_abs_q   <= b_abs_d;
            a_q       <= a_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = (state_q == StDone) ? res_final : result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table vectors, hand sequences for kill/reset/busy, and
// random operands against an arithmetic reference model. Two instances:
// dut0 with EARLY_OUT=1 and dut1 with EARLY_OUT=0.

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, start1, kill, kill1;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy0, done0, busy1, done1;
    logic [31:0] res0, res1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill), .busy_o(busy0), .done_o(done0), .result_o(res0)
    );

    div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .op_i(op), .a_i(a), .b_i(b),
        .kill_i(kill1), .busy_o(busy1), .done_o(done1), .result_o(res1)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] o, logic [31:0] x, logic [31:0] y,
                                logic [31:0] e, int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.exp = e; v.lat = l;
        return v;
    endfunction

    // RISC-V M semantics straight from the arithmetic definitions.
    function automatic logic [31:0] model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        int  sx = x;
        int  sy = y;
        bit  ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            2'd0: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
            2'd1: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'd2: return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(bit which, logic [1:0] o, logic [31:0] x, logic [31:0] y);
        if (which) return 33;
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op on an idle instance; returns the result and the number of
    // cycles from the accept edge to the done cycle (-1 on timeout).
    task automatic run_op(input bit which, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] r, output int lat);
        @(negedge clk);
        op = o; a = x; b = y;
        if (which) start1 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start1 = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        lat = -1;
        r   = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if ((which ? done1 : done0) === 1'b1) begin
                lat = c;
                r   = which ? res1 : res0;
                break;
            end
        end
    endtask

    logic [31:0] r, prior;
    int          lat;
    bit          seen;

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; kill = 1'b0; kill1 = 1'b0;
        op = 2'd0; a = '0; b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy0", {31'd0, busy0}, 32'd0);
        check("reset_done0", {31'd0, done0}, 32'd0);
        check("reset_res0", res0, 32'd0);
        check("reset_res1", res1, 32'd0);
        rst = 1'b0;

        vecs.push_back(mk(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(2'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33));
        vecs.push_back(mk(2'd1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33));
        vecs.push_back(mk(2'd1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1));
        vecs.push_back(mk(2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 1));
        vecs.push_back(mk(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
        vecs.push_back(mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1));
        vecs.push_back(mk(2'd0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1));
        vecs.push_back(mk(2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1));
        vecs.push_back(mk(2'd0, 32'd100, 32'd7, 32'd14, 33));
        vecs.push_back(mk(2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33));
        vecs.push_back(mk(2'd0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33));
        vecs.push_back(mk(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33));
        vecs.push_back(mk(2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33));
        vecs.push_back(mk(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33));

        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                run_op(w[0], vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
                check($sformatf("vec%0d_dut%0d_res", i, w), r, vecs[i].exp);
                check($sformatf("vec%0d_dut%0d_lat", i, w), 32'(lat),
                      32'(w[0] ? 33 : vecs[i].lat));
                @(negedge clk);
                check($sformatf("vec%0d_dut%0d_pulse", i, w),
                      {30'd0, (w[0] ? done1 : done0), (w[0] ? busy1 : busy0)}, 32'd0);
            end
        end

        // Kill in the 10th CALC cycle: no done, held result unchanged
        run_op(1'b0, 2'd1, 32'd5000, 32'd7, prior, lat);
        check("pre_kill_res", prior, 32'd714);
        @(negedge clk);
        op = 2'd0; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {31'd0, busy0}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done0) seen = 1'b1;
            @(negedge clk);
        end
        check("kill_no_done", {31'd0, seen}, 32'd0);
        check("kill_res_held", res0, prior);
        run_op(1'b0, 2'd0, 32'd1000, 32'd3, r, lat);
        check("post_kill_res", r, 32'd333);
        check("post_kill_lat", 32'(lat), 32'd33);

        // A start while busy is ignored
        @(negedge clk);
        op = 2'd0; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 5) begin
                op = 2'd3; a = 32'd5; b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done0) begin
                lat = c;
                r   = res0;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_res", r, 32'd142);
        check("busy_start_lat", 32'(lat), 32'd33);
        @(negedge clk);
        check("busy_start_idle", {31'd0, busy0}, 32'd0);

        // Reset in the 5th CALC cycle
        @(negedge clk);
        op = 2'd1; a = 32'd999; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_done", {31'd0, done0}, 32'd0);
        check("midrst_res", res0, 32'd0);

        // Random operands against the model
        for (int i = 0; i < 1200; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            bit          w;
            int unsigned sel;
            ro  = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            w   = (i % 8 == 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 20);
            else if (sel == 3) rb = -32'($urandom_range(1, 20));
            else if (sel == 4) ra = $urandom_range(0, 100);
            run_op(w, ro, ra, rb, r, lat);
            check($sformatf("rnd%0d_op%0d_%h_%h_res", i, ro, ra, rb), r, model(ro, ra, rb));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(w, ro, ra, rb)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
